// File: rtl/dispatch_buffer_if.sv
// Shared IF->dispatch packet type and the dispatch buffer bus interface.
package dispatch_buffer_pkg;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
  } if_id_t;

  localparam int FU_ALU  = 0;
  localparam int FU_ACU  = 1;
  localparam int FU_MULT = 2;

  localparam logic [31:0] WFI_INST = 32'h1050_0073;

endpackage

interface dispatch_buffer_if #(
  parameter int IN_W   = 2,
  parameter int OUT_W  = 2,
  parameter int FU_NUM = 3
);
  import dispatch_buffer_pkg::*;

  localparam int CW = $clog2(OUT_W + 1);

  if_id_t [IN_W-1:0]                if_packet_in;
  logic                             stall_out;
  logic   [FU_NUM-1:0][CW-1:0]      rs_free;
  logic   [CW-1:0]                  rob_free;
  if_id_t [OUT_W-1:0]               dis_packet;
  logic   [OUT_W-1:0]               dis_valid;
  logic   [OUT_W-1:0][FU_NUM-1:0]   dis_fu;

  modport master (
    output if_packet_in, rs_free, rob_free,
    input  stall_out, dis_packet, dis_valid, dis_fu
  );

  modport slave (
    input  if_packet_in, rs_free, rob_free,
    output stall_out, dis_packet, dis_valid, dis_fu
  );

endinterface

// File: rtl/dispatch_buffer.sv
// N-wide in-order dispatch queue with RS/ROB credit gating and WFI halt.
// Optional zero-latency bypass when empty: define DISPATCH_BYPASS_EN.
module dispatch_buffer
  import dispatch_buffer_pkg::*;
#(
  parameter  int IN_W   = 2,
  parameter  int OUT_W  = 2,
  parameter  int DEPTH  = 8,
  parameter  int FU_NUM = 3,
  localparam int PW     = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  dispatch_buffer_if.slave bus,
  output logic [PW-1:0]    count,
  output logic             halted
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(OUT_W + 1);
  localparam int MI = (FU_NUM > 2) ? FU_MULT : FU_ALU;

  typedef enum logic {RUN, HALTED} state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     head_q, head_d;
  logic [AW-1:0]     tail_q, tail_d;
  logic [PW-1:0]     count_q, count_d;
  if_id_t            buf_q [DEPTH];

  if_id_t            cand  [OUT_W];
  logic [OUT_W-1:0]  avail;
  logic [FU_NUM-1:0] fu    [OUT_W];
  logic [CW-1:0]     used  [FU_NUM];
  logic              byp;
  logic              ok;
  logic              cred;
  logic              wfi_hit;
  int                n_dis;

  logic              stall;
  logic              acc_ok;
  int                n_val;
  int                skip;
  int                n_acc;
  int                n_pop;
  logic [AW-1:0]     widx;
  logic [DEPTH-1:0]  wr_en;
  if_id_t            wr_data [DEPTH];

  function automatic logic [FU_NUM-1:0] classify(
    input logic [31:0] inst
  );
    logic [FU_NUM-1:0] f;
    logic              is_mem;
    logic              is_mul;
    is_mem = (inst[6:0] == 7'b0000011)
          || (inst[6:0] == 7'b0100011);
    is_mul = (inst[6:0] == 7'b0110011)
          && (inst[31:25] == 7'b0000001);
    f = '0;
    unique case (1'b1)
      is_mem:  f[FU_ACU] = 1'b1;
      is_mul:  f[MI]     = 1'b1;
      default: f[FU_ALU] = 1'b1;
    endcase
    return f;
  endfunction

  // Dispatch selection: oldest first, stop at first slot lacking credit.
  always_comb begin
    byp = 1'b0;
`ifdef DISPATCH_BYPASS_EN
    byp = (count_q == '0) && (state_q == RUN);
`endif
    for (int k = 0; k < OUT_W; k++) begin
      if (byp) begin
        cand[k]  = (k < IN_W) ? bus.if_packet_in[k % IN_W] : '0;
        avail[k] = cand[k].valid;
      end else begin
        cand[k]  = buf_q[head_q + AW'(k)];
        avail[k] = PW'(k) < count_q;
      end
      fu[k] = avail[k] ? classify(cand[k].inst) : '0;
    end

    ok            = (state_q == RUN) && !flush;
    wfi_hit       = 1'b0;
    n_dis         = 0;
    bus.dis_valid = '0;
    for (int c = 0; c < FU_NUM; c++) used[c] = '0;

    for (int k = 0; k < OUT_W; k++) begin
      cred = 1'b1;
      for (int c = 0; c < FU_NUM; c++) begin
        used[c] = used[c] + CW'(fu[k][c]);
        if (fu[k][c] && (used[c] > bus.rs_free[c])) cred = 1'b0;
      end
      ok = ok && avail[k] && cred
         && (CW'(k) < bus.rob_free);
      bus.dis_valid[k] = ok;
      if (ok) begin
        n_dis = n_dis + 1;
        if (cand[k].inst == WFI_INST) begin
          wfi_hit = 1'b1;
          ok      = 1'b0;
        end
      end
      bus.dis_packet[k] = avail[k] ? cand[k] : '0;
      bus.dis_fu[k]     = fu[k];
    end
  end

  // Accept path; bypassed packets are never written.
  always_comb begin
    stall  = (DEPTH - int'(count_q)) < IN_W;
    acc_ok = reset && !flush && !stall;
    n_val  = 0;
    for (int j = 0; j < IN_W; j++) begin
      if (bus.if_packet_in[j].valid) n_val = n_val + 1;
    end
    skip  = byp ? n_dis : 0;
    n_acc = acc_ok ? (n_val - skip) : 0;
    n_pop = byp ? 0 : n_dis;

    wr_en = '0;
    widx  = '0;
    for (int e = 0; e < DEPTH; e++) wr_data[e] = '0;
    for (int j = 0; j < IN_W; j++) begin
      if (acc_ok && bus.if_packet_in[j].valid && (j >= skip)) begin
        widx          = tail_q + AW'(j - skip);
        wr_en[widx]   = 1'b1;
        wr_data[widx] = bus.if_packet_in[j];
      end
    end

    bus.stall_out = stall;
  end

  always_comb begin
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + AW'(n_pop);
      tail_d  = tail_q + AW'(n_acc);
      count_d = count_q + PW'(n_acc) - PW'(n_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    always_ff @(posedge clock) begin
      if (wr_en[g]) buf_q[g] <= wr_data[g];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) state_q <= RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (wfi_hit) state_d = HALTED;
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
    if (flush) state_d = RUN;
  end

  always_comb begin
    halted = (state_q == HALTED);
    count  = count_q;
  end

endmodule
